// File: rtl/memory_access_stage_if.sv
// Bundle of the EX/MEM handshake, the data-RAM port and the WB result bus seen by the MEM stage.
// The master side is whoever feeds the stage and owns the RAM; the slave side is the stage itself.
interface memory_access_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic        in_reg_write;
    logic [4:0]  in_rd;

    logic        mem_ena;
    logic [3:0]  mem_wea;
    logic [11:0] mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta;

    logic        out_valid;
    logic        out_reg_write;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_fault;

    modport master (
        output in_valid, in_mem_read, in_mem_write, in_size, in_unsigned,
               in_addr, in_store_data, in_reg_write, in_rd, mem_douta,
        input  in_ready, mem_ena, mem_wea, mem_addra, mem_dina,
               out_valid, out_reg_write, out_rd, out_data, out_fault
    );

    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_size, in_unsigned,
               in_addr, in_store_data, in_reg_write, in_rd, mem_douta,
        output in_ready, mem_ena, mem_wea, mem_addra, mem_dina,
               out_valid, out_reg_write, out_rd, out_data, out_fault
    );
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: drives the data RAM with lane-steered stores, waits one cycle for load data,
// then sign/zero-extends it and registers the result (or an alignment/range fault) toward WB.
module memory_access_stage (
    input  logic                 clk,
    input  logic                 reset,
    memory_access_stage_if.slave bus
);

    typedef enum logic {IDLE, LOAD_WAIT} state_e;

    state_e      state_q;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        reg_write_q;
    logic [4:0]  rd_q;

    logic        out_valid_q;
    logic        out_reg_write_q;
    logic        out_fault_q;
    logic [4:0]  out_rd_q;
    logic [31:0] out_data_q;

    logic        in_ready_w;
    logic        accept;
    logic        is_store;
    logic        is_load;
    logic        mem_op;
    logic        size_half;
    logic        size_word;
    logic        fault;
    logic        access;
    logic [3:0]  wea_lanes;
    logic [31:0] dina_lanes;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;

    assign in_ready_w = (state_q == IDLE) && !reset;
    assign accept     = bus.in_valid && in_ready_w;
    assign is_store   = bus.in_mem_write;
    assign is_load    = bus.in_mem_read && !bus.in_mem_write;
    assign mem_op     = is_store || is_load;
    assign size_half  = (bus.in_size == 2'b01);
    assign size_word  = bus.in_size[1];

    assign fault = mem_op && ((size_half && bus.in_addr[0]) ||
                              (size_word && (bus.in_addr[1:0] != 2'b00)) ||
                              (bus.in_addr[31:14] != 18'd0));
    assign access = accept && mem_op && !fault;

    // Little-endian lane steering: replicate the store data so every enabled lane sees its byte.
    always_comb begin
        wea_lanes  = 4'b1111;
        dina_lanes = bus.in_store_data;
        if (bus.in_size == 2'b00) begin
            wea_lanes  = 4'b0001 << bus.in_addr[1:0];
            dina_lanes = {4{bus.in_store_data[7:0]}};
        end else if (size_half) begin
            wea_lanes  = bus.in_addr[1] ? 4'b1100 : 4'b0011;
            dina_lanes = {2{bus.in_store_data[15:0]}};
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.mem_ena   = access;
    assign bus.mem_wea   = (access && is_store) ? wea_lanes : 4'b0000;
    assign bus.mem_addra = access ? bus.in_addr[13:2] : 12'd0;
    assign bus.mem_dina  = (access && is_store) ? dina_lanes : 32'd0;

    assign lane_byte = bus.mem_douta[{offset_q, 3'b000} +: 8];
    assign lane_half = offset_q[1] ? bus.mem_douta[31:16] : bus.mem_douta[15:0];

    always_comb begin
        load_value = bus.mem_douta;
        case (size_q)
            2'b00:   load_value = unsigned_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_value = unsigned_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_value = bus.mem_douta;
        endcase
    end

    // Reset wins over LOAD_WAIT so a pending load is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            offset_q        <= 2'b00;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            reg_write_q     <= 1'b0;
            rd_q            <= 5'd0;
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_fault_q     <= 1'b0;
            out_rd_q        <= 5'd0;
            out_data_q      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        if (is_load && !fault) begin
                            offset_q    <= bus.in_addr[1:0];
                            size_q      <= bus.in_size;
                            unsigned_q  <= bus.in_unsigned;
                            reg_write_q <= bus.in_reg_write;
                            rd_q        <= bus.in_rd;
                            state_q     <= LOAD_WAIT;
                        end else begin
                            out_valid_q     <= 1'b1;
                            out_fault_q     <= fault;
                            out_rd_q        <= bus.in_rd;
                            out_reg_write_q <= !fault && !mem_op && bus.in_reg_write;
                            out_data_q      <= fault ? 32'd0 : bus.in_addr;
                        end
                    end
                end
                LOAD_WAIT: begin
                    out_valid_q     <= 1'b1;
                    out_fault_q     <= 1'b0;
                    out_rd_q        <= rd_q;
                    out_reg_write_q <= reg_write_q;
                    out_data_q      <= load_value;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_reg_write = out_reg_write_q;
    assign bus.out_fault     = out_fault_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_data      = out_data_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: a byte-array memory model predicts every RAM port value and
// WB result; directed scenarios cover the stall, fault and reset cases, then random ops follow.
module tb_memory_access_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_access_stage_if bus();

    memory_access_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the block RAM: read-first, one-cycle registered read, byte write enables.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.mem_ena) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wea[i]) ram[bus.mem_addra][8*i +: 8] <= bus.mem_dina[8*i +: 8];
            bus.mem_douta <= ram[bus.mem_addra];
        end
    end

    logic [7:0]  refMem [0:16383];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] obsData;
    logic [31:0] b2bLoadExp;
    logic [31:0] b2bStoreData;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refRead(input int a, input int nbytes, input logic uns);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(refMem[a + i]) << (8 * i));
        if (!uns && v[8*nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
        return v;
    endfunction

    task automatic driveFields(input logic rdOp, input logic wrOp, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data,
                               input logic regw, input logic [4:0] rd);
        bus.in_mem_read   = rdOp;
        bus.in_mem_write  = wrOp;
        bus.in_size       = size;
        bus.in_unsigned   = uns;
        bus.in_addr       = addr;
        bus.in_store_data = data;
        bus.in_reg_write  = regw;
        bus.in_rd         = rd;
    endtask

    // One operation in isolation: check the RAM port at accept, then the WB result.
    task automatic applyStimulus(input logic rdOp, input logic wrOp, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] data,
                                 input logic regw, input logic [4:0] rd);
        logic        isStore = wrOp;
        logic        isLoad  = rdOp && !wrOp;
        logic        memOp   = isStore || isLoad;
        int          nbytes  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        int          a       = int'(addr[13:0]);
        logic        fault;
        logic [3:0]  expWea;
        logic [31:0] expDina;
        logic [31:0] expLoad;

        fault   = memOp && (((addr % nbytes) != 0) || (addr >= 32'h4000));
        expWea  = 4'(((1 << nbytes) - 1) << (addr % 4));
        expDina = (nbytes == 1) ? {4{data[7:0]}} : (nbytes == 2) ? {2{data[15:0]}} : data;
        expLoad = fault ? 32'd0 : refRead(a, nbytes, uns);

        @(negedge clk);
        driveFields(rdOp, wrOp, size, uns, addr, data, regw, rd);
        bus.in_valid = 1'b1;
        #1;
        checkOutput("accept_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mem_ena", 32'(bus.mem_ena), 32'(memOp && !fault));
        checkOutput("mem_wea", 32'(bus.mem_wea), (isStore && !fault) ? 32'(expWea) : 32'd0);
        if (memOp && !fault) checkOutput("mem_addra", 32'(bus.mem_addra), 32'(addr[13:2]));
        if (isStore && !fault) checkOutput("mem_dina", bus.mem_dina, expDina);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (isLoad && !fault) begin
            @(negedge clk);
            checkOutput("load_wait_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("load_wait_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        obsData = bus.out_data;
        checkOutput("out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("out_fault", 32'(bus.out_fault), 32'(fault));
        checkOutput("out_data", bus.out_data, fault ? 32'd0 : (isLoad ? expLoad : addr));
        checkOutput("out_reg_write", 32'(bus.out_reg_write), (fault || isStore) ? 32'd0 : 32'(regw));
        if (!fault && !isStore) checkOutput("out_rd", 32'(bus.out_rd), 32'(rd));
        if (isStore && !fault)
            for (int i = 0; i < nbytes; i++) refMem[a + i] = data[8*i +: 8];
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        for (int i = 0; i < 16384; i++) refMem[i] = 8'd0;
        bus.mem_douta = 32'd0;

        // Reset with a store offered: nothing may reach the RAM.
        reset = 1'b1;
        driveFields(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678, 1'b0, 5'd0);
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("reset_mem_ena", 32'(bus.mem_ena), 32'd0);
        checkOutput("reset_mem_wea", 32'(bus.mem_wea), 32'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", bus.out_data, 32'd0);
        checkOutput("reset_out_rd", 32'(bus.out_rd), 32'd0);
        checkOutput("reset_out_fault", 32'(bus.out_fault), 32'd0);
        checkOutput("reset_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h7, 32'h0000_00A5, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 1'b1, 5'd2);
        checkOutput("plan_word_load", obsData, 32'hA5AD_BEEF);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h7, 32'd0, 1'b1, 5'd5);
        checkOutput("plan_byte_signed", obsData, 32'hFFFF_FFA5);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h7, 32'd0, 1'b1, 5'd5);
        checkOutput("plan_byte_unsigned", obsData, 32'h0000_00A5);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'd0, 1'b1, 5'd5);
        checkOutput("plan_half_signed", obsData, 32'hFFFF_A5AD);

        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h1111_2222, 1'b1, 5'd9);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFE_F00D, 1'b1, 5'd1);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_0003, 32'd0, 1'b1, 5'd12);

        // Back-to-back pass-through, load, store to the loaded word with in_valid held.
        b2bLoadExp   = refRead(16, 4, 1'b0);
        b2bStoreData = $urandom;
        @(negedge clk);
        driveFields(1'b0, 1'b0, 2'b10, 1'b0, 32'h123, 32'd0, 1'b1, 5'd3);
        bus.in_valid = 1'b1;
        #1 checkOutput("b2b_c0_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 driveFields(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 5'd7);
        @(negedge clk);
        checkOutput("b2b_c1_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_c1_out_data", bus.out_data, 32'h123);
        checkOutput("b2b_c1_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 driveFields(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, b2bStoreData, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("b2b_c2_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("b2b_c2_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("b2b_c2_mem_ena", 32'(bus.mem_ena), 32'd0);
        @(negedge clk);
        checkOutput("b2b_c3_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_c3_load_data", bus.out_data, b2bLoadExp);
        checkOutput("b2b_c3_out_rd", 32'(bus.out_rd), 32'd7);
        checkOutput("b2b_c3_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("b2b_c3_mem_wea", 32'(bus.mem_wea), 32'hF);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) refMem[16 + i] = b2bStoreData[8*i +: 8];
        @(negedge clk);
        checkOutput("b2b_c4_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_c4_out_data", bus.out_data, 32'h10);
        checkOutput("b2b_c4_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 5'd4);

        // Reset arriving while a load waits for its data must discard it.
        @(negedge clk);
        driveFields(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 1'b1, 5'd6);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_lw_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_lw_mem_ena", 32'(bus.mem_ena), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_lw_out_valid_a", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_lw_in_ready_after", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        checkOutput("rst_lw_out_valid_b", 32'(bus.out_valid), 32'd0);

        // Random mix, mostly aligned accesses into a small window so loads hit earlier stores.
        for (int n = 0; n < 120; n++) begin
            int          kind = $urandom_range(0, 3);
            int          pick = $urandom_range(0, 9);
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] addr;
            if (pick == 0) addr = $urandom | 32'h0000_4000;
            else           addr = 32'($urandom_range(0, 127));
            if (pick > 0 && pick < 7) begin
                if (size[1])              addr[1:0] = 2'b00;
                else if (size == 2'b01)   addr[0]   = 1'b0;
            end
            applyStimulus(kind == 1, kind >= 2, size, 1'($urandom_range(0, 1)), addr,
                          $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
